// File: rtl/fir_pkg.sv
// Shared constants and the rounding helper for the FIR output stage.
package fir_pkg;

    localparam int FIR_Y_W   = 9;
    localparam int SUM_W     = FIR_Y_W + 1;
    localparam int DECIM_DEF = 2;
    localparam int OUT_W_DEF = 6;
    localparam int DEPTH_DEF = 4;

    // Round-half-up then drop s LSBs; kept SUM_W wide so a carry past OUT_W stays visible.
    function automatic logic [SUM_W-1:0] round_shift(input logic [FIR_Y_W-1:0] y, input int s);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, y};
        if (s > 0) sum = sum + (SUM_W'(1) << (s - 1));
        return sum >> s;
    endfunction

endpackage

// File: rtl/fir_output_stage_if.sv
// Sample-in / FIFO-out bundle of the FIR output stage; slave is the stage, master its environment.
interface fir_output_stage_if
    import fir_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [FIR_Y_W-1:0] i_y_n;
    logic               i_y_valid;
    logic               i_clr_ovf;
    logic [OUT_W-1:0]   o_data;
    logic               o_valid;
    logic               i_ready;
    logic [CNT_W-1:0]   o_count;
    logic               o_overflow;

    modport master (
        output i_y_n, i_y_valid, i_clr_ovf, i_ready,
        input  o_data, o_valid, o_count, o_overflow
    );

    modport slave (
        input  i_y_n, i_y_valid, i_clr_ovf, i_ready,
        output o_data, o_valid, o_count, o_overflow
    );

endinterface

// File: rtl/fir_out_fifo.sv
// Show-ahead FIFO; a push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module fir_out_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    // NOTE: every signal here is assigned on every path, so no latch is inferred.
    always_comb begin
        full    = (cnt == CW'(DEPTH));
        empty   = (cnt == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage is not reset; an empty FIFO masks it, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata   = empty ? '0 : mem[rd_ptr];
    assign valid   = !empty;
    assign count   = cnt;
    assign dropped = push && !do_push;

endmodule

// File: rtl/fir_output_stage.sv
// Decimates, rounds and queues FIR results. Define FIR_OUT_SAT_EN to saturate
// out-of-range rounded samples; otherwise they wrap to their low OUT_W bits.
module fir_output_stage
    import fir_pkg::*;
#(
    parameter int DECIM = DECIM_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic               i_CLK,
    input  logic               i_RST_N,
    fir_output_stage_if.slave  bus
);

    localparam int S    = FIR_Y_W - OUT_W;
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int CW   = $clog2(DEPTH + 1);

    logic [PH_W-1:0]  phase;
    logic             keep;
    logic [OUT_W-1:0] rounded;
    logic             s1_push;
    logic [OUT_W-1:0] s1_data;
    logic             fifo_pop;
    logic             fifo_dropped;
    logic             fifo_valid;
    logic [OUT_W-1:0] fifo_rdata;
    logic [CW-1:0]    fifo_count;
    logic             overflow;

    assign keep = bus.i_y_valid && (phase == '0);

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            phase <= '0;
        end else if (bus.i_y_valid) begin
            phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
        end
    end

`ifdef FIR_OUT_SAT_EN
    localparam logic [SUM_W-1:0] MAX_CODE = SUM_W'((1 << OUT_W) - 1);
    logic [SUM_W-1:0] scaled;

    always_comb begin
        scaled  = round_shift(bus.i_y_n, S);
        rounded = (scaled > MAX_CODE) ? OUT_W'(MAX_CODE) : OUT_W'(scaled);
    end
`else
    always_comb begin
        rounded = OUT_W'(round_shift(bus.i_y_n, S));
    end
`endif

    // Stage 1: register the rounded sample; the FIFO write is stage 2.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            s1_push <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_push <= keep;
            s1_data <= rounded;
        end
    end

    assign fifo_pop = fifo_valid && bus.i_ready;

    fir_out_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_CLK),
        .rst_n   (i_RST_N),
        .push    (s1_push),
        .wdata   (s1_data),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .valid   (fifo_valid),
        .count   (fifo_count),
        .dropped (fifo_dropped)
    );

    // A drop in the same cycle as a clear request leaves the flag set.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            overflow <= 1'b0;
        end else if (fifo_dropped) begin
            overflow <= 1'b1;
        end else if (bus.i_clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign bus.o_data     = fifo_rdata;
    assign bus.o_valid    = fifo_valid;
    assign bus.o_count    = fifo_count;
    assign bus.o_overflow = overflow;

endmodule

// File: tb/tb_fir_output_stage.sv
// Directed bench for fir_output_stage: a DECIM=2 and a DECIM=1 instance on a shared clock and reset.
module tb_fir_output_stage;
    import fir_pkg::*;

    localparam int OUT_W = 6;
    localparam int DEPTH = 4;

`ifdef FIR_OUT_SAT_EN
    localparam logic [OUT_W-1:0] EXP_511 = 6'd63;
`else
    localparam logic [OUT_W-1:0] EXP_511 = 6'd0;
`endif

    typedef struct {
        logic [8:0]       y;
        logic             valid;
        logic             exp_valid;
        logic [OUT_W-1:0] exp_data;
        logic [2:0]       exp_count;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   pops;
    vec_t vecs [8];

    fir_output_stage_if #(.OUT_W(OUT_W), .DEPTH(DEPTH)) if_a ();
    fir_output_stage_if #(.OUT_W(OUT_W), .DEPTH(DEPTH)) if_b ();

    fir_output_stage #(.DECIM(2), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut_a (
        .i_CLK   (clk),
        .i_RST_N (rst_n),
        .bus     (if_a)
    );

    fir_output_stage #(.DECIM(1), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut_b (
        .i_CLK   (clk),
        .i_RST_N (rst_n),
        .bus     (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [8:0] y, input logic v);
        if_a.i_y_n     = y;
        if_a.i_y_valid = v;
    endtask

    task automatic drive_b(input logic [8:0] y, input logic v);
        if_b.i_y_n     = y;
        if_b.i_y_valid = v;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive_a(9'd0, 1'b0);
        drive_b(9'd0, 1'b0);
        if_a.i_clr_ovf = 1'b0;
        if_b.i_clr_ovf = 1'b0;
        if_a.i_ready   = 1'b0;
        if_b.i_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Row i's expected outputs belong to the input of row i-2.
        vecs[0] = '{9'd8,   1'b1, 1'b0, 6'd0,    3'd0};
        vecs[1] = '{9'd9,   1'b1, 1'b0, 6'd0,    3'd0};
        vecs[2] = '{9'd16,  1'b1, 1'b1, 6'd1,    3'd1};
        vecs[3] = '{9'd17,  1'b1, 1'b0, 6'd0,    3'd0};
        vecs[4] = '{9'd511, 1'b1, 1'b1, 6'd2,    3'd1};
        vecs[5] = '{9'd0,   1'b0, 1'b0, 6'd0,    3'd0};
        vecs[6] = '{9'd0,   1'b0, 1'b1, EXP_511, 3'd1};
        vecs[7] = '{9'd0,   1'b0, 1'b0, 6'd0,    3'd0};

        rst_n = 1'b0;
        drive_a(9'd0, 1'b0);
        drive_b(9'd0, 1'b0);
        if_a.i_clr_ovf = 1'b0;
        if_b.i_clr_ovf = 1'b0;
        if_a.i_ready   = 1'b0;
        if_b.i_ready   = 1'b0;
        #3;
        check("reset a valid",    32'(if_a.o_valid),    32'd0);
        check("reset a count",    32'(if_a.o_count),    32'd0);
        check("reset a data",     32'(if_a.o_data),     32'd0);
        check("reset a overflow", 32'(if_a.o_overflow), 32'd0);
        check("reset b valid",    32'(if_b.o_valid),    32'd0);
        check("reset b count",    32'(if_b.o_count),    32'd0);
        check("reset b data",     32'(if_b.o_data),     32'd0);
        check("reset b overflow", 32'(if_b.o_overflow), 32'd0);

        // Decimate by 2, round and saturate/wrap with a consumer that is always ready.
        apply_reset();
        if_a.i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_a(vecs[i].y, vecs[i].valid);
            @(negedge clk);
            check($sformatf("vec%0d valid", i), 32'(if_a.o_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d data", i),  32'(if_a.o_data),  32'(vecs[i].exp_data));
            check($sformatf("vec%0d count", i), 32'(if_a.o_count), 32'(vecs[i].exp_count));
            step();
        end
        check("vec overflow", 32'(if_a.o_overflow), 32'd0);

        // DECIM=1, stalled consumer: six pushes of 40 fill the FIFO and drop two.
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive_b(9'd40, 1'b1);
            step();
        end
        drive_b(9'd0, 1'b0);
        repeat (3) step();
        @(negedge clk);
        check("stall count",    32'(if_b.o_count),    32'd4);
        check("stall overflow", 32'(if_b.o_overflow), 32'd1);
        check("stall head",     32'(if_b.o_data),     32'd5);
        step();
        if_b.i_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (if_b.o_valid) begin
                pops++;
                check($sformatf("drain data %0d", pops), 32'(if_b.o_data), 32'd5);
            end
            step();
        end
        check("drain pops",  32'(pops),          32'd4);
        check("drain count", 32'(if_b.o_count),  32'd0);

        // Full FIFO with a push and a pop in the same cycle.
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            if (k < 5) drive_b(9'(8 * (k + 1)), 1'b1);
            else       drive_b(9'd0, 1'b0);
            if_b.i_ready = (k == 5);
            @(negedge clk);
            if (k == 4) begin
                check("hold head", 32'(if_b.o_data),  32'd1);
                check("hold count", 32'(if_b.o_count), 32'd3);
            end
            if (k == 5) begin
                check("full count",    32'(if_b.o_count),    32'd4);
                check("full head",     32'(if_b.o_data),     32'd1);
                check("full overflow", 32'(if_b.o_overflow), 32'd0);
            end
            if (k == 6) begin
                check("pushpop count",    32'(if_b.o_count),    32'd4);
                check("pushpop head",     32'(if_b.o_data),     32'd2);
                check("pushpop overflow", 32'(if_b.o_overflow), 32'd0);
            end
            if (k == 7) check("after pushpop count", 32'(if_b.o_count), 32'd4);
            step();
        end

        // Clear request coinciding with the first drop, then a clear on its own.
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            if (k < 5) drive_b(9'd40, 1'b1);
            else       drive_b(9'd0, 1'b0);
            if_b.i_clr_ovf = (k == 5) || (k == 6);
            @(negedge clk);
            if (k == 5) check("pre-drop overflow", 32'(if_b.o_overflow), 32'd0);
            if (k == 6) begin
                check("set-wins overflow", 32'(if_b.o_overflow), 32'd1);
                check("drop count",        32'(if_b.o_count),    32'd4);
            end
            if (k == 7) check("cleared overflow", 32'(if_b.o_overflow), 32'd0);
            step();
        end
        if_b.i_clr_ovf = 1'b0;

        // Reset mid-operation with three entries queued and one sample in stage 1.
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            if (k < 7) drive_a(9'd40, 1'b1);
            else       drive_a(9'd0, 1'b0);
            @(negedge clk);
            if (k == 7) check("pre-reset count", 32'(if_a.o_count), 32'd3);
            if (k < 7) step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset valid",    32'(if_a.o_valid),    32'd0);
        check("async reset count",    32'(if_a.o_count),    32'd0);
        check("async reset data",     32'(if_a.o_data),     32'd0);
        check("async reset overflow", 32'(if_a.o_overflow), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 0)      drive_a(9'd16, 1'b1);
            else if (k == 1) drive_a(9'd24, 1'b1);
            else             drive_a(9'd0, 1'b0);
            @(negedge clk);
            if (k == 1) check("post-reset flushed count", 32'(if_a.o_count), 32'd0);
            if (k == 2) begin
                check("post-reset valid", 32'(if_a.o_valid), 32'd1);
                check("post-reset data",  32'(if_a.o_data),  32'd2);
                check("post-reset count", 32'(if_a.o_count), 32'd1);
            end
            if (k == 4) begin
                check("post-reset phase count", 32'(if_a.o_count), 32'd1);
                check("post-reset phase head",  32'(if_a.o_data),  32'd2);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_output_stage.md
FIR_OUTPUT_STAGE -- requirements
Module: fir_output_stage

Interface
REQ-001 Parameter: DECIM, default 2, decimation ratio (legal 1..16).
REQ-002 Parameter: OUT_W, default 6, output sample width (legal 1..9).
REQ-003 Parameter: DEPTH, default 4, output FIFO depth in entries (power of two, 2..16).
REQ-004 Port: i_CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port: i_RST_N  input  1  reset, asynchronous assert, active-low.
REQ-006 Port: i_y_n  input  9  unsigned filter-result sample from the upstream FIR filter.
REQ-007 Port: i_y_valid  input  1  i_y_n holds a new sample this cycle.
REQ-008 Port: i_clr_ovf  input  1  clears the sticky overflow flag.
REQ-009 Port: o_data  output  OUT_W  FIFO head sample.
REQ-010 Port: o_valid  output  1  o_data is valid (FIFO not empty).
REQ-011 Port: i_ready  input  1  consumer accepts o_data; a pop occurs when o_valid && i_ready.
REQ-012 Port: o_count  output  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-013 Port: o_overflow  output  1  sticky flag: a decimated sample was dropped.

Function
REQ-014 The phase counter shall count i_y_valid cycles modulo DECIM. The first valid sample after reset is kept (phase 0), along with every DECIM-th valid sample after it. Other samples are discarded. DECIM=1 keeps every sample.
REQ-015 Each kept sample shall be scaled to OUT_W bits by a right shift of S=9-OUT_W with round-half-up: add 2^(S-1) when S>0, then shift. The intermediate sum is 10 bits wide.
REQ-016 A rounded value exceeding 2^OUT_W-1 shall be handled as defined in Configuration.
REQ-017 Stage 1 shall register the rounded sample with a push flag. Stage 2 writes it to the FIFO.
REQ-018 A kept sample at cycle N shall appear on o_data with o_valid=1 at cycle N+2 when the FIFO is empty at N+1.
REQ-019 The FIFO is show-ahead: o_data always equals the oldest entry while o_valid=1.
REQ-020 When the FIFO is full and no pop occurs in the same cycle, a push shall be dropped. In that case o_overflow is set and the FIFO contents and o_count are unchanged.
REQ-021 When the FIFO is full and a push and pop coincide, both shall complete and o_count shall stay at DEPTH.
REQ-022 When the FIFO is empty, a pop request shall be impossible because o_valid=0. A push while empty shall not be visible until the following cycle.
REQ-023 When a push and pop coincide on a non-full, non-empty FIFO, o_count shall be unchanged.
REQ-024 Read and write pointers shall wrap modulo DEPTH.
REQ-025 If an overflow event and i_clr_ovf occur in the same cycle, o_overflow shall be 1 afterwards (set wins).
REQ-026 o_data shall hold its value while o_valid=1 and i_ready=0.

Reset
REQ-027 Asserting i_RST_N low shall immediately force o_valid=0, o_count=0, o_overflow=0, o_data=0, the phase counter to 0, the stage-1 push flag to 0, and both pointers to 0.
REQ-028 Reset mid-operation shall discard all FIFO contents and in-flight samples. The first valid sample after release is phase 0.

Configuration
REQ-029 Macro FIR_OUT_SAT_EN defined: a rounded value above 2^OUT_W-1 shall saturate to 2^OUT_W-1.
REQ-030 Macro FIR_OUT_SAT_EN undefined: a rounded value shall be truncated to its low OUT_W bits (wrap).

Structure
REQ-031 Package fir_pkg shall hold the constant FIR_Y_W=9 and the default parameter constants for DECIM, OUT_W and DEPTH.
REQ-032 The FIFO shall be the sub-module fir_out_fifo, parameterised by width and depth and exposing push/pop/count. The decimation and rounding logic stays in fir_output_stage.

Verification
REQ-033 Defaults, i_ready=1, valid samples 8,9,16,17,511: kept 8,16,511. Outputs are 1,2,63 (sat enabled) or 1,2,0 (sat disabled), each 2 cycles after its input.
REQ-034 DECIM=1, i_ready=0, 6 consecutive valid samples of 40: o_count reaches 4 and o_overflow=1. After i_ready=1, exactly four values of 5 are popped.
REQ-035 FIFO full with i_ready=1 and a push in the same cycle: o_count stays 4 and o_overflow stays 0.
REQ-036 i_clr_ovf pulsed in the same cycle as an overflow drop: o_overflow=1. i_clr_ovf pulsed alone next cycle: o_overflow=0.
REQ-037 i_RST_N asserted with 3 entries queued and a sample in stage 1: o_valid=0 and o_count=0 immediately. After release, the next valid sample is kept as phase 0.
